// File: rtl/gpu_column_drawer_pkg.sv
// Shared GPU package for the column drawer.
// Holds the default screen/texture geometry, the ceiling/floor colours
// and the column-drawer FSM state encoding.
package gpu_column_drawer_pkg;

    localparam int GPU_SCREEN_WIDTH  = 320;
    localparam int GPU_SCREEN_HEIGHT = 240;
    localparam int GPU_TEXTURE_SIZE  = 64;

    localparam logic [7:0] GPU_CEIL_COLOR  = 8'h11;
    localparam logic [7:0] GPU_FLOOR_COLOR = 8'h22;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ROW     = 3'd1;
    localparam logic [2:0] ST_TEXWAIT = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/gpu_column_drawer_if.sv
// Bus bundle between the column drawer and its environment.
//   start/column_x/distance/uv_x : column request, sampled on an accepted start
//   tex_rd_en/tex_addr/tex_rdata : texture ROM read, data one cycle after the strobe
//   fb_wr_*/fb_addr/fb_data      : framebuffer write channel
//   busy/done                    : column status
// Framebuffer handshake: a write transfers on a rising clock edge where
// fb_wr_valid and fb_wr_ready are both high; once fb_wr_valid is raised it
// stays high, and fb_addr/fb_data stay unchanged, until that edge.
// master = the column drawer, slave = the texture ROM / framebuffer side.
interface gpu_column_drawer_if;
    logic        start;
    logic [8:0]  column_x;
    logic [15:0] distance;
    logic [5:0]  uv_x;
    logic        tex_rd_en;
    logic [11:0] tex_addr;
    logic [7:0]  tex_rdata;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy;
    logic        done;

    modport master (
        input  start, column_x, distance, uv_x, tex_rdata, fb_wr_ready,
        output tex_rd_en, tex_addr, fb_wr_valid, fb_addr, fb_data, busy, done
    );

    modport slave (
        output start, column_x, distance, uv_x, tex_rdata, fb_wr_ready,
        input  tex_rd_en, tex_addr, fb_wr_valid, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/gpuLookup.sv
// Wall-slice lookup for one screen row.
// Wall height in rows = SCREEN_HEIGHT(Q8.8) / distance(Q8.8); the slice is
// centred on the middle row. A row is inside the wall when it lies strictly
// between top = mid - h/2 and bottom = mid + h/2.
//   row         : screen row
//   distance    : Q8.8 wall distance
//   inside_wall : row lies on the wall slice
//   uv_y        : texture row (unsaturated), (row - top) * TEXTURE_SIZE / h
module gpuLookup #(
    parameter logic [15:0] SCREEN_HEIGHT = 16'hF000,
    parameter int          TEXTURE_SIZE  = 64
) (
    input  logic [7:0]  row,
    input  logic [15:0] distance,
    output logic        inside_wall,
    output logic [15:0] uv_y
);
    localparam logic signed [17:0] MID_ROW = $signed(18'(SCREEN_HEIGHT >> 9));

    logic [15:0]        wall_h;
    logic signed [17:0] top;
    logic signed [17:0] bottom;
    logic signed [17:0] row_s;
    logic signed [17:0] offset;
    logic [23:0]        quotient;

    always_comb begin
        wall_h   = 16'd0;
        quotient = 24'd0;
        // A zero distance yields a zero-height slice rather than a divide by zero.
        if (distance != 16'd0) begin
            wall_h = SCREEN_HEIGHT / distance;
        end
        top         = MID_ROW - $signed({3'b000, wall_h[15:1]});
        bottom      = MID_ROW + $signed({3'b000, wall_h[15:1]});
        row_s       = $signed({10'd0, row});
        offset      = row_s - top;
        inside_wall = (row_s > top) && (row_s < bottom);
        // inside_wall implies wall_h > 0, so the divisor is never zero here.
        if (inside_wall) begin
            quotient = (24'($unsigned(offset)) * 24'(TEXTURE_SIZE)) / {8'd0, wall_h};
        end
        uv_y = (quotient > 24'h00FFFF) ? 16'hFFFF : quotient[15:0];
    end
endmodule

// File: rtl/gpu_column_drawer.sv
// Column drawer: renders one vertical screen column into the framebuffer.
// For each row 0..SCREEN_HEIGHT-1 it either fetches a texel (wall rows) or
// uses the ceiling/floor colour, then issues one framebuffer write.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request, texture ROM and framebuffer signals (master side)
//   dbg_state  : current FSM state for observation
module gpu_column_drawer
    import gpu_column_drawer_pkg::*;
#(
    parameter int         SCREEN_WIDTH  = GPU_SCREEN_WIDTH,
    parameter int         SCREEN_HEIGHT = GPU_SCREEN_HEIGHT,
    parameter int         TEXTURE_SIZE  = GPU_TEXTURE_SIZE,
    parameter logic [7:0] CEIL_COLOR    = GPU_CEIL_COLOR,
    parameter logic [7:0] FLOOR_COLOR   = GPU_FLOOR_COLOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gpu_column_drawer_if.master  bus,
    output logic [2:0]           dbg_state
);
    localparam logic [7:0]  LAST_ROW = 8'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]  HALF_ROW = 8'(SCREEN_HEIGHT / 2);
    localparam logic [15:0] TEX_MAX  = 16'(TEXTURE_SIZE - 1);

    logic [2:0]  state;
    logic [7:0]  row;
    logic [8:0]  col_q;
    logic [15:0] dist_q;
    logic [5:0]  uvx_q;
    logic [16:0] addr_q;
    logic [7:0]  pix_q;

    logic        inside_wall;
    logic [15:0] uv_y_raw;
    logic [5:0]  uv_y;
    logic [16:0] row_addr;

    gpuLookup #(
        .SCREEN_HEIGHT (16'hF000),
        .TEXTURE_SIZE  (TEXTURE_SIZE)
    ) u_lookup (
        .row         (row),
        .distance    (dist_q),
        .inside_wall (inside_wall),
        .uv_y        (uv_y_raw)
    );

    assign uv_y     = (uv_y_raw > TEX_MAX) ? TEX_MAX[5:0] : uv_y_raw[5:0];
    assign row_addr = 17'(row) * 17'(SCREEN_WIDTH) + 17'(col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            row    <= 8'd0;
            col_q  <= 9'd0;
            dist_q <= 16'd0;
            uvx_q  <= 6'd0;
            addr_q <= 17'd0;
            pix_q  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        col_q  <= bus.column_x;
                        dist_q <= (bus.distance == 16'd0) ? 16'h0001 : bus.distance;
                        uvx_q  <= bus.uv_x;
                        row    <= 8'd0;
                        state  <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    addr_q <= row_addr;
                    if (inside_wall) begin
                        state <= ST_TEXWAIT;
                    end else begin
                        pix_q <= (row < HALF_ROW) ? CEIL_COLOR : FLOOR_COLOR;
                        state <= ST_WRITE;
                    end
                end
                ST_TEXWAIT: begin
                    pix_q <= bus.tex_rdata;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bus.fb_wr_ready) begin
                        if (row == LAST_ROW) begin
                            state <= ST_DONE;
                        end else begin
                            row   <= row + 8'd1;
                            state <= ST_ROW;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state so reset clears them in the same cycle.
    assign bus.tex_rd_en   = (state == ST_ROW) && inside_wall;
    assign bus.tex_addr    = bus.tex_rd_en ? {uv_y, uvx_q} : 12'd0;
    assign bus.fb_wr_valid = (state == ST_WRITE);
    assign bus.fb_addr     = addr_q;
    assign bus.fb_data     = pix_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_gpu_column_drawer.sv
module tb_gpu_column_drawer;
    localparam int W = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    gpu_column_drawer_if bus_if ();

    gpu_column_drawer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    int write_count = 0;
    int done_count = 0;
    int ceil_count = 0;
    int floor_count = 0;
    logic [16:0] last_addr = '0;
    logic [16:0] first_addr = '0;
    logic [7:0]  first_data = '0;
    logic [W-1:0] exp_q[$];

    function automatic logic [7:0] tex_fn(input logic [11:0] a);
        logic [7:0] v;
        v = 8'(a[11:6]) * 8'd5 + 8'(a[5:0]) * 8'd3 + 8'h40;
        return v;
    endfunction

    // Reference: wall height 240/dist rows centred on row 120; ceiling above
    // the middle, floor below; distance 0 treated as 1/256.
    function automatic logic [W-1:0] exp_write(input int r, input int col, input int d, input int ux);
        int dd, h, half, uy;
        logic [7:0]  px;
        logic [11:0] ta;
        logic [16:0] fa;
        dd = (d == 0) ? 1 : d;
        h = 61440 / dd;
        half = h / 2;
        if ((r - 120) < half && (120 - r) < half) begin
            uy = ((r - 120 + half) * 64) / h;
            if (uy > 63) uy = 63;
            ta = {6'(uy), 6'(ux)};
            px = tex_fn(ta);
        end else begin
            px = (r < 120) ? 8'h11 : 8'h22;
        end
        fa = 17'(r * 320 + col);
        return {fa, px};
    endfunction

    // Texture ROM: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus_if.tex_rdata <= bus_if.tex_rd_en ? tex_fn(bus_if.tex_addr) : 8'hEE;
    end

    // Write monitor: every accepted framebuffer write is checked against the queue.
    always @(negedge clk) begin
        logic [W-1:0] got, exp;
        if (rst_n && bus_if.fb_wr_valid === 1'b1 && bus_if.fb_wr_ready === 1'b1) begin
            got = {bus_if.fb_addr, bus_if.fb_data};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", bus_if.fb_addr, bus_if.fb_data);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             got[24:8], got[7:0], exp[24:8], exp[7:0]);
                end
            end
            if (write_count == 0) begin
                first_addr = bus_if.fb_addr;
                first_data = bus_if.fb_data;
            end
            if (bus_if.fb_data == 8'h11) ceil_count++;
            if (bus_if.fb_data == 8'h22) floor_count++;
            write_count++;
            last_addr = bus_if.fb_addr;
        end
        if (bus_if.done === 1'b1) done_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic start_column(input int col, input int d, input int ux);
        @(posedge clk); #1;
        write_count = 0; done_count = 0; ceil_count = 0; floor_count = 0;
        bus_if.column_x = 9'(col);
        bus_if.distance = 16'(d);
        bus_if.uv_x     = 6'(ux);
        bus_if.start    = 1'b1;
        for (int r = 0; r < 240; r++) exp_q.push_back(exp_write(r, col, d, ux));
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) seen = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.fb_wr_valid !== 1'b0 || bus_if.tex_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got valid=%b rd_en=%b, required 0 0", bus_if.fb_wr_valid, bus_if.tex_rd_en);
        end
        n_checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b done=%b, required 0 0", bus_if.busy, bus_if.done);
        end
        n_checks++;
        if (bus_if.fb_addr !== 17'd0 || bus_if.fb_data !== 8'd0 || bus_if.tex_addr !== 12'd0) begin
            n_fail++; $display("FAIL reset_buses: got fb_addr=%0d fb_data=%h tex_addr=%h, required 0", bus_if.fb_addr, bus_if.fb_data, bus_if.tex_addr);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_near_wall();
        bit seen;
        bus_if.fb_wr_ready = 1'b1;
        start_column(5, 16'h0100, 3);
        wait_done(3000, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL near_timeout: got no done, required done"); end
        n_checks++;
        if (write_count !== 240) begin n_fail++; $display("FAIL near_writes: got %0d, required 240", write_count); end
        n_checks++;
        if (done_count !== 1) begin n_fail++; $display("FAIL near_done_pulses: got %0d, required 1", done_count); end
        n_checks++;
        if (first_addr !== 17'd5 || first_data !== 8'h11) begin
            n_fail++; $display("FAIL near_first: got addr=%0d data=%h, required 5 11", first_addr, first_data);
        end
        n_checks++;
        if (last_addr !== 17'd76485) begin n_fail++; $display("FAIL near_last_addr: got %0d, required 76485", last_addr); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL near_busy_after: got %b, required 0", bus_if.busy); end
    endtask

    task automatic test_far_wall();
        bit seen;
        bus_if.fb_wr_ready = 1'b1;
        start_column(17, 16'h0400, 9);
        wait_done(3000, seen);
        n_checks++;
        if (!seen || write_count !== 240) begin
            n_fail++; $display("FAIL far_writes: got done=%b writes=%0d, required 1 240", seen, write_count);
        end
        n_checks++;
        if (ceil_count !== 91) begin n_fail++; $display("FAIL far_ceiling_rows: got %0d, required 91", ceil_count); end
        n_checks++;
        if (floor_count !== 90) begin n_fail++; $display("FAIL far_floor_rows: got %0d, required 90", floor_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL far_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        int hold = 0;
        logic [16:0] target, cap_addr;
        logic [7:0]  cap_data;
        target = 17'(10 * 320 + 33);
        cap_addr = '0; cap_data = '0;
        bus_if.fb_wr_ready = 1'b1;
        start_column(33, 16'h0200, 20);
        for (int i = 0; i < 6000 && !seen; i++) begin
            if (bus_if.fb_wr_valid === 1'b1 && bus_if.fb_addr === target && hold < 5) begin
                if (hold == 0) begin
                    cap_addr = bus_if.fb_addr;
                    cap_data = bus_if.fb_data;
                end
                bus_if.fb_wr_ready = 1'b0;
                hold++;
                @(negedge clk);
                n_checks++;
                if (bus_if.fb_wr_valid !== 1'b1 || bus_if.fb_addr !== cap_addr || bus_if.fb_data !== cap_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b addr=%0d data=%h, required 1 %0d %h",
                             bus_if.fb_wr_valid, bus_if.fb_addr, bus_if.fb_data, cap_addr, cap_data);
                end
            end else begin
                bus_if.fb_wr_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            if (bus_if.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        bus_if.fb_wr_ready = 1'b1;
        n_checks++;
        if (hold !== 5) begin n_fail++; $display("FAIL stall_cycles: got %0d, required 5", hold); end
        n_checks++;
        if (!seen || write_count !== 240) begin
            n_fail++; $display("FAIL stall_writes: got done=%b writes=%0d, required 1 240", seen, write_count);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_start_ignored();
        bit seen, found = 1'b0;
        bus_if.fb_wr_ready = 1'b1;
        start_column(7, 16'h0300, 40);
        for (int i = 0; i < 3000 && !found; i++) begin
            if (bus_if.fb_wr_valid === 1'b1 && bus_if.fb_addr === 17'(50 * 320 + 7)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!found || bus_if.busy !== 1'b1) begin
            n_fail++; $display("FAIL ign_reach_row50: got found=%b busy=%b, required 1 1", found, bus_if.busy);
        end
        bus_if.start = 1'b1; bus_if.column_x = 9'd100; bus_if.distance = 16'h0080; bus_if.uv_x = 6'd1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_done(3000, seen);
        n_checks++;
        if (!seen || write_count !== 240 || done_count !== 1) begin
            n_fail++; $display("FAIL ign_writes: got done=%b writes=%0d pulses=%0d, required 1 240 1", seen, write_count, done_count);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ign_queue: got %0d left, required 0", exp_q.size()); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL ign_restarted: got busy=%b, required 0", bus_if.busy); end
    endtask

    task automatic test_reset_mid();
        bit seen, found = 1'b0;
        int wc;
        bus_if.fb_wr_ready = 1'b1;
        start_column(200, 16'h0100, 0);
        for (int i = 0; i < 3000 && !found; i++) begin
            if (bus_if.fb_wr_valid === 1'b1 && bus_if.fb_addr === 17'(100 * 320 + 200)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rst_reach_row100: got not reached, required reached"); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.fb_wr_valid !== 1'b0 || bus_if.tex_rd_en !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobes: got valid=%b rd=%b busy=%b done=%b, required 0",
                               bus_if.fb_wr_valid, bus_if.tex_rd_en, bus_if.busy, bus_if.done);
        end
        n_checks++;
        if (bus_if.fb_addr !== 17'd0 || bus_if.fb_data !== 8'd0 || bus_if.tex_addr !== 12'd0) begin
            n_fail++; $display("FAIL rst_mid_buses: got fb_addr=%0d fb_data=%h tex_addr=%h, required 0",
                               bus_if.fb_addr, bus_if.fb_data, bus_if.tex_addr);
        end
        exp_q.delete();
        wc = write_count;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (write_count !== wc) begin n_fail++; $display("FAIL rst_no_writes: got %0d, required %0d", write_count, wc); end
        start_column(200, 16'h0100, 0);
        wait_done(3000, seen);
        n_checks++;
        if (!seen || write_count !== 240 || first_addr !== 17'd200) begin
            n_fail++; $display("FAIL rst_restart: got done=%b writes=%0d first=%0d, required 1 240 200", seen, write_count, first_addr);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rst_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_distance_zero();
        bit seen = 1'b0, x_seen = 1'b0;
        bus_if.fb_wr_ready = 1'b1;
        start_column(319, 16'h0000, 63);
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if ($isunknown({bus_if.tex_rd_en, bus_if.tex_addr, bus_if.fb_wr_valid, bus_if.fb_addr,
                            bus_if.fb_data, bus_if.busy, bus_if.done})) x_seen = 1'b1;
            if (bus_if.done === 1'b1) seen = 1'b1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (x_seen) begin n_fail++; $display("FAIL dz_unknown: got X on an output, required none"); end
        n_checks++;
        if (!seen || write_count !== 240) begin
            n_fail++; $display("FAIL dz_writes: got done=%b writes=%0d, required 1 240", seen, write_count);
        end
        n_checks++;
        if (last_addr !== 17'd76799) begin n_fail++; $display("FAIL dz_max_addr: got %0d, required 76799", last_addr); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL dz_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus_if.start = 1'b0;
        bus_if.column_x = '0;
        bus_if.distance = '0;
        bus_if.uv_x = '0;
        bus_if.fb_wr_ready = 1'b0;
        test_reset();
        test_near_wall();
        test_far_wall();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_distance_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
